dm_cache: RTL and testbench

Direct-mapped, write-back, write-allocate data cache that responds to the cache-controller handshake (`valid_i` / `miss_o` / `ready_o`) on the CPU side. It performs line writeback and refill over a word-serial request/acknowledge memory port. Hits complete combinationally in the request cycle. A miss blocks the cache, with `ready_o` low, until the line is resident; the controller then retries the access.

---
 rtl/dm_cache.sv | 142 ++++++++++++++
 tb/tb_dm_cache.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_cache.sv
// dm_cache: direct-mapped, write-back, write-allocate data cache.
// Hits resolve combinationally; misses stall the CPU side while the victim
// line is written back (if dirty) and the new line is refilled word-serially.
module dm_cache #(
    parameter int unsigned LINES = 16,
    parameter int unsigned WORDS = 4
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        valid_i,
    input  logic [31:0] addr_i,
    input  logic        write_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  wstrb_i,
    output logic [31:0] rdata_o,
    output logic        miss_o,
    output logic        ready_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int unsigned WB = $clog2(WORDS);
    localparam int unsigned IB = $clog2(LINES);
    localparam int unsigned TB = 30 - WB - IB;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITEBACK,
        S_REFILL
    } state_t;

    state_t          state_q;
    logic [WB-1:0]   cnt_q, cnt_d;
    logic [IB-1:0]   lidx_q;
    logic [TB-1:0]   ltag_q;
    logic [LINES-1:0] valid_q, dirty_q;
    logic [TB-1:0]   tag_q  [LINES];
    logic [31:0]     data_q [LINES][WORDS];

    logic [WB-1:0]   word_i;
    logic [IB-1:0]   idx_i;
    logic [TB-1:0]   tag_i;
    logic            hit, last_word, store_hit, wb_ack, rf_ack;
    logic [TB-1:0]   mem_tag;
    logic            unused_addr;

    assign word_i      = addr_i[2 +: WB];
    assign idx_i       = addr_i[2 + WB +: IB];
    assign tag_i       = addr_i[31 -: TB];
    assign unused_addr = ^addr_i[1:0];

    // Lookup, handshake and memory-port decode
    always_comb begin
        hit         = valid_q[idx_i] && (tag_q[idx_i] == tag_i);
        last_word   = (cnt_q == WB'(WORDS - 1));
        cnt_d       = cnt_q + WB'(1);
        ready_o     = (state_q == S_IDLE);
        miss_o      = ready_o && valid_i && !hit;
        store_hit   = ready_o && valid_i && write_i && hit;
        wb_ack      = (state_q == S_WRITEBACK) && mem_ack_i;
        rf_ack      = (state_q == S_REFILL) && mem_ack_i;
        rdata_o     = data_q[idx_i][word_i];
        mem_req_o   = (state_q != S_IDLE);
        mem_we_o    = (state_q == S_WRITEBACK);
        mem_tag     = mem_we_o ? tag_q[lidx_q] : ltag_q;
        mem_addr_o  = {mem_tag, lidx_q, cnt_q, 2'b00};
        mem_wdata_o = data_q[lidx_q][cnt_q];
    end

    // Controller FSM with per-line valid/dirty state
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            lidx_q  <= '0;
            ltag_q  <= '0;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (store_hit) begin
                        dirty_q[idx_i] <= 1'b1;
                    end else if (miss_o) begin
                        lidx_q <= idx_i;
                        ltag_q <= tag_i;
                        cnt_q  <= '0;
                        if (valid_q[idx_i] && dirty_q[idx_i]) begin
                            state_q <= S_WRITEBACK;
                        end else begin
                            valid_q[idx_i] <= 1'b0;
                            state_q        <= S_REFILL;
                        end
                    end
                end
                S_WRITEBACK: begin
                    if (mem_ack_i) begin
                        cnt_q <= cnt_d;
                        if (last_word) begin
                            valid_q[lidx_q] <= 1'b0;
                            dirty_q[lidx_q] <= 1'b0;
                            state_q         <= S_REFILL;
                        end
                    end
                end
                S_REFILL: begin
                    if (mem_ack_i) begin
                        cnt_q <= cnt_d;
                        if (last_word) begin
                            valid_q[lidx_q] <= 1'b1;
                            dirty_q[lidx_q] <= 1'b0;
                            state_q         <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Tag and data arrays (not reset): store-hit byte merge and refill writes
    always_ff @(posedge clk_i) begin
        if (store_hit) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (wstrb_i[b]) begin
                    data_q[idx_i][word_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
        if (rf_ack) begin
            data_q[lidx_q][cnt_q] <= mem_rdata_i;
            if (last_word) begin
                tag_q[lidx_q] <= ltag_q;
            end
        end
    end

endmodule

// File: tb/tb_dm_cache.sv
// tb_dm_cache: directed scoreboard bench for dm_cache. Stimulus pushes the
// expected CPU responses and memory transfers; a monitor pops and compares.
module tb_dm_cache;

    logic        clk_i = 1'b0;
    logic        reset_ni;
    logic        valid_i, write_i;
    logic [31:0] addr_i, wdata_i;
    logic [3:0]  wstrb_i;
    logic [31:0] rdata_o;
    logic        miss_o, ready_o, mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;

    dm_cache #(.LINES(16), .WORDS(4)) dut (
        .clk_i       (clk_i),
        .reset_ni    (reset_ni),
        .valid_i     (valid_i),
        .addr_i      (addr_i),
        .write_i     (write_i),
        .wdata_i     (wdata_i),
        .wstrb_i     (wstrb_i),
        .rdata_o     (rdata_o),
        .miss_o      (miss_o),
        .ready_o     (ready_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        miss;
        logic        chk;
        logic [31:0] rdata;
    } cpu_exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_exp_t;

    cpu_exp_t cpu_q[$];
    mem_exp_t mem_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int ack_period = 1;
    int ack_ctr    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Backing memory contents for refills
    function automatic logic [31:0] memval(input logic [31:0] a);
        case (a)
            32'h100: return 32'h11111111;
            32'h104: return 32'h22222222;
            32'h108: return 32'h33333333;
            32'h10C: return 32'h44444444;
            default: return a ^ 32'hA5A50000;
        endcase
    endfunction

    // Memory responder: ack every ack_period-th requesting cycle
    always @(posedge clk_i) begin
        #1;
        if (mem_req_o) begin
            ack_ctr++;
            if (ack_ctr >= ack_period) begin
                mem_ack_i = 1'b1;
                ack_ctr   = 0;
            end else begin
                mem_ack_i = 1'b0;
            end
        end else begin
            mem_ack_i = 1'b0;
            ack_ctr   = 0;
        end
        mem_rdata_i = memval(mem_addr_o);
    end

    // Monitor: scoreboard pops plus hold-stability during ack stalls
    logic        prev_stall = 1'b0;
    logic        prev_we;
    logic [31:0] prev_addr, prev_wdata;
    always @(negedge clk_i) begin
        if (!reset_ni) begin
            prev_stall = 1'b0;
        end else begin
            if (valid_i && ready_o) begin
                if (cpu_q.size() == 0) begin
                    check("cpu_unexpected_access", 32'(valid_i), 32'd0);
                end else begin
                    cpu_exp_t e;
                    e = cpu_q.pop_front();
                    check("miss_o", 32'(miss_o), 32'(e.miss));
                    if (e.chk) check("rdata_o", rdata_o, e.rdata);
                end
            end
            if (prev_stall && mem_req_o) begin
                check("stall_addr_hold", mem_addr_o, prev_addr);
                check("stall_we_hold", 32'(mem_we_o), 32'(prev_we));
                if (prev_we) check("stall_wdata_hold", mem_wdata_o, prev_wdata);
            end
            if (mem_req_o && mem_ack_i) begin
                if (mem_q.size() == 0) begin
                    check("mem_unexpected_xfer", mem_addr_o, 32'hFFFFFFFF);
                end else begin
                    mem_exp_t m;
                    m = mem_q.pop_front();
                    check("mem_we_o", 32'(mem_we_o), 32'(m.we));
                    check("mem_addr_o", mem_addr_o, m.addr);
                    if (m.we) check("mem_wdata_o", mem_wdata_o, m.wdata);
                end
            end
            prev_stall = mem_req_o && !mem_ack_i;
            prev_we    = mem_we_o;
            prev_addr  = mem_addr_o;
            prev_wdata = mem_wdata_o;
        end
    end

    task automatic push_mem(input logic we, input logic [31:0] a, input logic [31:0] d);
        mem_exp_t m;
        m.we = we; m.addr = a; m.wdata = d;
        mem_q.push_back(m);
    endtask

    task automatic push_refill(input logic [31:0] base);
        for (int unsigned w = 0; w < 4; w++) push_mem(1'b0, base + 32'(4 * w), 32'h0);
    endtask

    // One-cycle CPU access with its expected response
    task automatic access(input logic wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic exp_miss, input logic chk,
                          input logic [31:0] exp_rdata);
        cpu_exp_t e;
        e.miss = exp_miss; e.chk = chk; e.rdata = exp_rdata;
        cpu_q.push_back(e);
        @(posedge clk_i); #1;
        valid_i = 1'b1; write_i = wr; addr_i = a; wdata_i = d; wstrb_i = s;
        @(posedge clk_i); #1;
        valid_i = 1'b0; write_i = 1'b0;
    endtask

    task automatic load(input logic [31:0] a, input logic exp_miss, input logic [31:0] exp_rdata);
        access(1'b0, a, 32'h0, 4'h0, exp_miss, !exp_miss, exp_rdata);
    endtask

    // Count ready_o-low cycles after a miss; optionally poke the CPU port mid-transfer
    task automatic wait_ready(input int exp_low, input logic poke, input logic [31:0] poke_addr);
        int lowcnt = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_i);
            if (ready_o) break;
            lowcnt++;
            if (poke && lowcnt == 5) begin
                valid_i = 1'b1; write_i = 1'b1; addr_i = poke_addr;
                wdata_i = 32'hFFFFFFFF; wstrb_i = 4'hF;
                #1;
                check("miss_o_while_busy", 32'(miss_o), 32'd0);
            end
            if (poke && lowcnt == 7) begin
                valid_i = 1'b0; write_i = 1'b0;
            end
        end
        check("ready_low_cycles", 32'(lowcnt), 32'(exp_low));
    endtask

    initial begin
        int acks;
        reset_ni = 1'b0;
        valid_i = 1'b0; write_i = 1'b0; addr_i = '0; wdata_i = '0; wstrb_i = '0;
        #3;
        check("reset_ready_o", 32'(ready_o), 32'd1);
        check("reset_mem_req_o", 32'(mem_req_o), 32'd0);
        check("reset_mem_we_o", 32'(mem_we_o), 32'd0);
        check("reset_miss_idle", 32'(miss_o), 32'd0);
        valid_i = 1'b1; addr_i = 32'h100;
        #1;
        check("reset_miss_follows_valid", 32'(miss_o), 32'd1);
        valid_i = 1'b0;
        @(negedge clk_i); @(negedge clk_i);
        reset_ni = 1'b1;

        // Cold miss and refill, then retry
        push_refill(32'h100);
        load(32'h100, 1'b1, 32'h0);
        wait_ready(4, 1'b0, 32'h0);
        load(32'h104, 1'b0, 32'h22222222);

        // Partial store hit: pre-write data visible in the store cycle
        access(1'b1, 32'h108, 32'hDEADBEEF, 4'b0011, 1'b0, 1'b1, 32'h33333333);
        load(32'h108, 1'b0, 32'h3333BEEF);

        // Dirty eviction: writeback of line 0 then refill from 0x200
        push_mem(1'b1, 32'h100, 32'h11111111);
        push_mem(1'b1, 32'h104, 32'h22222222);
        push_mem(1'b1, 32'h108, 32'h3333BEEF);
        push_mem(1'b1, 32'h10C, 32'h44444444);
        push_refill(32'h200);
        load(32'h200, 1'b1, 32'h0);
        wait_ready(8, 1'b0, 32'h0);
        load(32'h20C, 1'b0, 32'hA5A5020C);

        // Clean eviction: no writeback, first address 0x300
        push_refill(32'h300);
        load(32'h300, 1'b1, 32'h0);
        wait_ready(4, 1'b0, 32'h0);
        load(32'h304, 1'b0, 32'hA5A50304);

        // Ack stall every 3rd cycle with a CPU store attempted mid-refill
        ack_period = 3;
        push_refill(32'h410);
        load(32'h410, 1'b1, 32'h0);
        wait_ready(12, 1'b1, 32'h410);
        ack_period = 1;
        load(32'h410, 1'b0, 32'hA5A50410);
        load(32'h418, 1'b0, 32'hA5A50418);

        // Reset after two refill acks
        push_mem(1'b0, 32'h100, 32'h0);
        push_mem(1'b0, 32'h104, 32'h0);
        load(32'h100, 1'b1, 32'h0);
        acks = 0;
        for (int i = 0; i < 50 && acks < 2; i++) begin
            @(negedge clk_i);
            if (mem_req_o && mem_ack_i) acks++;
        end
        check("acks_before_reset", 32'(acks), 32'd2);
        @(posedge clk_i); #2;
        reset_ni = 1'b0;
        #1;
        check("midreset_mem_req_o", 32'(mem_req_o), 32'd0);
        check("midreset_ready_o", 32'(ready_o), 32'd1);
        @(negedge clk_i);
        reset_ni = 1'b1;
        push_refill(32'h100);
        load(32'h100, 1'b1, 32'h0);
        wait_ready(4, 1'b0, 32'h0);
        load(32'h108, 1'b0, 32'h33333333);

        repeat (3) @(negedge clk_i);
        check("cpu_queue_drained", 32'(cpu_q.size()), 32'd0);
        check("mem_queue_drained", 32'(mem_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
